// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq
//   Iterative unsigned multiply/divide sequencer (MUL, MULHU, DIVU, REMU) that
//   borrows the core ALU for one ADD or SUB per cycle. It keeps the partial
//   product or partial remainder in a local {hi, lo} register pair.
//   Multiply uses shift-add. Divide uses the restoring algorithm.
//   Every operation takes 32 iterations.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request; accepted only while ready=1 and abort=0
//   op         00 MUL (lo32), 01 MULHU (hi32), 10 DIVU, 11 REMU
//   src_a      multiplicand / dividend, sampled on accept
//   src_b      multiplier / divisor, sampled on accept
//   abort      flush; kills any in-flight operation
//   ready      1 in IDLE and DONE
//   busy       1 in RUN; the core routes alu_a/alu_b/alu_ctrl into its ALU
//   alu_a      ALU operand 1 drive
//   alu_b      ALU operand 2 drive
//   alu_ctrl   ALU control drive
//   alu_result ALU result, combinational from alu_a/alu_b/alu_ctrl
//   done       one-cycle pulse, result valid
//   result     final value, held until overwritten by the next completion
module alu_muldiv_seq #(
   parameter int         XLEN    = 32,
   parameter logic [3:0] ALU_ADD = 4'b0010,
   parameter logic [3:0] ALU_SUB = 4'b0011
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic            abort,
   output logic            ready,
   output logic            busy,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [3:0]      alu_ctrl,
   input  logic [XLEN-1:0] alu_result,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          state_reg, state_next;
   logic [1:0]      op_reg;
   logic [XLEN-1:0] b_reg, hi_reg, lo_reg, result_reg;
   logic [CW-1:0]   count_reg;

   logic            accept;
   logic            is_div;
   logic [XLEN-1:0] rem_shift;
   logic [XLEN-1:0] sum_sel;
   logic            carry;
   logic            take;
   logic [XLEN-1:0] hi_step, lo_step;

   assign accept = start && !abort && (state_reg != S_RUN);
   assign is_div = op_reg[1];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= S_IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (accept) state_next = S_RUN;
         S_RUN: begin
            if (abort)                   state_next = S_IDLE;
            else if (count_reg == LAST)  state_next = S_DONE;
         end
         S_DONE:  state_next = accept ? S_RUN : S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Output logic. The ALU drive is parked at 0/0/ADD outside RUN.
   always_comb begin
      ready    = (state_reg != S_RUN);
      busy     = (state_reg == S_RUN);
      done     = (state_reg == S_DONE);
      alu_a    = '0;
      alu_b    = '0;
      alu_ctrl = ALU_ADD;
      if (state_reg == S_RUN) begin
         alu_a    = is_div ? rem_shift : hi_reg;
         alu_b    = b_reg;
         alu_ctrl = is_div ? ALU_SUB : ALU_ADD;
      end
   end

   // One iteration of the datapath.
   // The ALU only returns 32 bits, so the carry/borrow is rebuilt here
   // with a 32-bit unsigned compare.
   always_comb begin
      rem_shift = {hi_reg[XLEN-2:0], lo_reg[XLEN-1]};
      sum_sel   = lo_reg[0] ? alu_result : hi_reg;
      carry     = lo_reg[0] && (alu_result < hi_reg);
      // The bit shifted out of hi means the 33-bit remainder already exceeds B.
      take      = hi_reg[XLEN-1] || !(rem_shift < b_reg);
      if (is_div) begin
         hi_step = take ? alu_result : rem_shift;
         lo_step = {lo_reg[XLEN-2:0], take};
      end else begin
         hi_step = {carry, sum_sel[XLEN-1:1]};
         lo_step = {sum_sel[0], lo_reg[XLEN-1:1]};
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_reg     <= '0;
         b_reg      <= '0;
         hi_reg     <= '0;
         lo_reg     <= '0;
         count_reg  <= '0;
         result_reg <= '0;
      end else if (accept) begin
         op_reg    <= op;
         b_reg     <= src_b;
         hi_reg    <= '0;
         lo_reg    <= src_a;
         count_reg <= '0;
      end else if (state_reg == S_RUN && !abort) begin
         hi_reg    <= hi_step;
         lo_reg    <= lo_step;
         count_reg <= count_reg + CW'(1);
         // Ops 01 and 11 return the hi half.
         // Ops 00 and 10 return the lo half.
         if (count_reg == LAST)
            result_reg <= op_reg[0] ? hi_step : lo_step;
      end
   end

   assign result = result_reg;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
module tb_alu_muldiv_seq;

   localparam logic [3:0] ADD = 4'b0010;
   localparam logic [3:0] SUB = 4'b0011;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] src_a = '0, src_b = '0;
   logic        abort = 1'b0;
   logic        ready, busy, done;
   logic [31:0] alu_a, alu_b, alu_result, result;
   logic [3:0]  alu_ctrl;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] last_result = '0;

   always #5 clk = ~clk;

   // The core ALU: ADD or SUB, combinational.
   assign alu_result = (alu_ctrl == SUB) ? alu_a - alu_b : alu_a + alu_b;

   alu_muldiv_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a),
      .src_b(src_b), .abort(abort), .ready(ready), .busy(busy),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .done(done), .result(result)
   );

   // Reference: plain 64-bit arithmetic plus the RISC-V divide-by-zero rules.
   function automatic logic [31:0] ref_calc(logic [1:0] o, logic [31:0] a, logic [31:0] b);
      logic [63:0] p;
      p = {32'd0, a} * {32'd0, b};
      case (o)
         2'b00:   return p[31:0];
         2'b01:   return p[63:32];
         2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge. Presents a request that is accepted at the next posedge.
   task automatic start_op(logic [1:0] o, logic [31:0] a, logic [31:0] b);
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Follows an accepted op to its done pulse and checks the result.
   // Returns at the negedge of the DONE cycle.
   // When inject > 0, a competing start is raised during that RUN cycle.
   task automatic wait_done(logic [1:0] o, logic [31:0] a, logic [31:0] b, int inject);
      int  busy_cnt = 0;
      int  lat = 0;
      logic [31:0] exp;
      exp = ref_calc(o, a, b);
      for (int c = 1; c <= 40 && lat == 0; c++) begin
         @(negedge clk);
         if (c == 1) begin
            chk("drive_a", alu_a, o[1] ? {31'd0, a[31]} : 32'd0);
            chk("drive_b", alu_b, b);
            chk("drive_ctrl", {28'd0, alu_ctrl}, {28'd0, o[1] ? SUB : ADD});
         end
         if (inject > 0 && c == inject) begin
            start = 1'b1; op = ~o; src_a = $urandom; src_b = $urandom;
         end
         if (inject > 0 && c == inject + 1) start = 1'b0;
         if (busy) busy_cnt++;
         if (done) lat = c;
      end
      chk("latency", 32'(lat), 32'd33);
      chk("busy_cycles", 32'(busy_cnt), 32'd32);
      chk("ready_at_done", {31'd0, ready}, 32'd1);
      chk("idle_ctrl", {28'd0, alu_ctrl}, {28'd0, ADD});
      chk("result", result, exp);
      $display("op=%0d a=%h b=%h result=%h expected=%h latency=%0d", o, a, b, result, exp, lat);
      last_result = exp;
   endtask

   logic [1:0]  d_op [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11};
   logic [31:0] d_a  [8] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100,
                             32'h8000_0000, 32'd1234, 32'd1234};
   logic [31:0] d_b  [8] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7,
                             32'd3, 32'd0, 32'd0};

   initial begin
      int done_cnt;
      logic [1:0]  ro;
      logic [31:0] ra, rb;

      // Reset state
      #12;
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_ctrl", {28'd0, alu_ctrl}, {28'd0, ADD});
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors, issued back-to-back from each DONE cycle.
      for (int i = 0; i < 8; i++) begin
         start_op(d_op[i], d_a[i], d_b[i]);
         wait_done(d_op[i], d_a[i], d_b[i], 0);
      end

      // Random operations. Roughly one in eight has a zero divisor.
      for (int i = 0; i < 24; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if (i % 4 == 3) rb = rb >> $urandom_range(8, 28);
         start_op(ro, ra, rb);
         wait_done(ro, ra, rb, 0);
      end

      // A start raised while busy is ignored.
      start_op(2'b10, 32'd100, 32'd7);
      wait_done(2'b10, 32'd100, 32'd7, 5);

      // Abort in RUN cycle 10: return to IDLE, no done, result unchanged.
      start_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (10) @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_ready", {31'd0, ready}, 32'd1);
      done_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      chk("abort_no_done", 32'(done_cnt), 32'd0);
      chk("abort_result", result, last_result);
      $display("abort: done pulses=%0d result=%h", done_cnt, result);

      // Asynchronous reset between edges in the middle of RUN.
      start_op(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D);
      repeat (6) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_ready", {31'd0, ready}, 32'd1);
      chk("arst_result", result, 32'd0);
      last_result = '0;
      @(negedge clk);
      rst_n = 1'b1;
      done_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      chk("arst_no_done", 32'(done_cnt), 32'd0);
      $display("async reset: done pulses=%0d result=%h", done_cnt, result);

      // Normal operation after reset.
      start_op(2'b00, 32'd7, 32'd6);
      wait_done(2'b00, 32'd7, 32'd6, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
